// File: rtl/tl_pkg.sv
// Shared definitions for the timed traffic-light scheduler.
//   - Light encodings driven on La/Lb.
//   - State encoding for the six-phase intersection sequence.
package tl_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef enum logic [2:0] {
    S_AG = 3'd0,
    S_AY = 3'd1,
    S_AR = 3'd2,
    S_BG = 3'd3,
    S_BY = 3'd4,
    S_BR = 3'd5
  } state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: CNT_W-bit up-counter that saturates at all-ones.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (clears count)
//   i_clr  in   synchronous clear (phase change)
//   o_cnt  out  current count
module tl_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (r_cnt != '1)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/tl_sched_timed.sv
// Timed, demand-driven traffic-light scheduler for a two-street intersection.
// Green phases are bounded by GREEN_MIN/GREEN_MAX, followed by yellow and
// all-red clearance. Pedestrian requests are latched and served with a timed
// walk signal on the next entry into the corresponding green phase.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   Ta, Tb  in   car present on street A / B
//   pa_req  in   pedestrian request for A walk (level or pulse)
//   pb_req  in   pedestrian request for B walk
//   La, Lb  out  light for street A / B (00 green, 01 yellow, 10 red)
//   walk_a  out  pedestrian walk, only during A green
//   walk_b  out  pedestrian walk, only during B green
module tl_sched_timed
  import tl_pkg::*;
#(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 16,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       pa_req,
  input  logic       pb_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk_a,
  output logic       walk_b
);

  // Timer thresholds: the timer reads k during the (k+1)-th cycle of a phase.
  localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] C_ARD  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_timer;
  logic             w_clr;
  logic             w_dem_a, w_dem_b;
  logic             w_enter_ag, w_enter_bg;
  logic             w_walk_a, w_walk_b;
  logic             r_pa_pend, r_pb_pend;
  logic [CNT_W-1:0] r_walk_a_cnt, r_walk_b_cnt;

  assign w_dem_a = Ta | r_pa_pend;
  assign w_dem_b = Tb | r_pb_pend;

  // A walk counter only runs inside its own green; the green cannot end while
  // it is nonzero, so the state qualifier is a belt-and-braces guard.
  assign w_walk_a = (r_walk_a_cnt != '0) && (r_state == S_AG);
  assign w_walk_b = (r_walk_b_cnt != '0) && (r_state == S_BG);

  // ---------------------------------------------------------------------------
  // Phase timer, cleared on every state change.
  // ---------------------------------------------------------------------------
  assign w_clr = (w_next != r_state);

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .o_cnt (w_timer)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_AG;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      // Leave green only after the minimum, with no walk running, when the
      // other street wants service, and either our street is empty or we hit
      // the maximum (which is what prevents starvation under Ta&Tb).
      S_AG: if (w_timer >= C_GMIN && !w_walk_a && w_dem_b &&
                (!Ta || w_timer >= C_GMAX))
              w_next = S_AY;
      S_AY: if (w_timer == C_YEL) w_next = S_AR;
      S_AR: if (w_timer == C_ARD) w_next = S_BG;
      S_BG: if (w_timer >= C_GMIN && !w_walk_b && w_dem_a &&
                (!Tb || w_timer >= C_GMAX))
              w_next = S_BY;
      S_BY: if (w_timer == C_YEL) w_next = S_BR;
      S_BR: if (w_timer == C_ARD) w_next = S_AG;
      default: w_next = S_AG;
    endcase
  end

  assign w_enter_ag = (w_next == S_AG) && (r_state != S_AG);
  assign w_enter_bg = (w_next == S_BG) && (r_state != S_BG);

  // ---------------------------------------------------------------------------
  // Pedestrian pending bits and walk counters. A request seen on the very
  // edge that enters the green is served immediately rather than deferred.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pa_pend    <= 1'b0;
      r_walk_a_cnt <= '0;
    end else if (w_enter_ag && (r_pa_pend || pa_req)) begin
      r_pa_pend    <= 1'b0;
      r_walk_a_cnt <= C_WALK;
    end else begin
      if (r_walk_a_cnt != '0) r_walk_a_cnt <= r_walk_a_cnt - CNT_W'(1);
      if (pa_req)             r_pa_pend    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pb_pend    <= 1'b0;
      r_walk_b_cnt <= '0;
    end else if (w_enter_bg && (r_pb_pend || pb_req)) begin
      r_pb_pend    <= 1'b0;
      r_walk_b_cnt <= C_WALK;
    end else begin
      if (r_walk_b_cnt != '0) r_walk_b_cnt <= r_walk_b_cnt - CNT_W'(1);
      if (pb_req)             r_pb_pend    <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore light decode from the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    La = LT_RED;
    Lb = LT_RED;
    case (r_state)
      S_AG: La = LT_GREEN;
      S_AY: La = LT_YELLOW;
      S_BG: Lb = LT_GREEN;
      S_BY: Lb = LT_YELLOW;
      default: ;
    endcase
  end

  assign walk_a = w_walk_a;
  assign walk_b = w_walk_b;

endmodule

// File: tb/tb_tl_sched_timed.sv
module tb_tl_sched_timed;

  logic       clk = 1'b0;
  logic       reset, Ta, Tb, pa_req, pb_req;
  logic [1:0] La, Lb;
  logic       walk_a, walk_b;

  tl_sched_timed dut (
    .clk    (clk),
    .reset  (reset),
    .Ta     (Ta),
    .Tb     (Tb),
    .pa_req (pa_req),
    .pb_req (pb_req),
    .La     (La),
    .Lb     (Lb),
    .walk_a (walk_a),
    .walk_b (walk_b)
  );

  always #5 clk = ~clk;

  // One row = inputs held for n cycles; expected outputs are those visible
  // during each of those cycles (i.e. produced by the previous edges).
  typedef struct {
    logic       rst, ta, tb, pa, pb;
    int         n;
    logic       chk;
    logic [1:0] la, lb;
    logic       wa, wb;
  } row_t;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10;

  row_t rows[$];
  int   total = 0;
  int   passed = 0;

  function automatic void add(logic rst, logic ta, logic tb, logic pa, logic pb,
                              int n, logic chk, logic [1:0] la, logic [1:0] lb,
                              logic wa, logic wb);
    row_t r;
    r.rst = rst; r.ta = ta; r.tb = tb; r.pa = pa; r.pb = pb;
    r.n = n; r.chk = chk; r.la = la; r.lb = lb; r.wa = wa; r.wb = wb;
    rows.push_back(r);
  endfunction

  function automatic void rst2();
    add(1, 0, 0, 0, 0, 2, 0, G, R, 0, 0);
  endfunction

  task automatic check(string name, logic [5:0] act, logic [5:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got La/Lb/wa/wb=%b expected %b", name, act, exp);
  endtask

  initial begin
    reset = 1; Ta = 0; Tb = 0; pa_req = 0; pb_req = 0;

    // 1: A traffic only, A green holds.
    rst2();
    add(0, 1, 0, 0, 0, 40, 1, G, R, 0, 0);
    // 2: both streets busy, alternate at GREEN_MAX.
    rst2();
    add(0, 1, 1, 0, 0, 16, 1, G, R, 0, 0);
    add(0, 1, 1, 0, 0,  3, 1, Y, R, 0, 0);
    add(0, 1, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 1, 1, 0, 0, 16, 1, R, G, 0, 0);
    add(0, 1, 1, 0, 0,  3, 1, R, Y, 0, 0);
    add(0, 1, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 1, 1, 0, 0, 16, 1, G, R, 0, 0);
    add(0, 1, 1, 0, 0,  1, 1, Y, R, 0, 0);
    // 3: B only, A green lasts GREEN_MIN, then B green holds.
    rst2();
    add(0, 0, 1, 0, 0,  8, 1, G, R, 0, 0);
    add(0, 0, 1, 0, 0,  3, 1, Y, R, 0, 0);
    add(0, 0, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 0, 1, 0, 0, 20, 1, R, G, 0, 0);
    // 4: pb_req pulse at cycle 2 alone drives the handover and a B walk.
    rst2();
    add(0, 0, 0, 0, 0,  2, 1, G, R, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, G, R, 0, 0);
    add(0, 0, 0, 0, 0,  5, 1, G, R, 0, 0);
    add(0, 0, 0, 0, 0,  3, 1, Y, R, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 0, 0, 0, 0,  6, 1, R, G, 0, 1);
    add(0, 0, 0, 0, 0, 10, 1, R, G, 0, 0);
    // 5: pa_req during A green is deferred to the next A green.
    rst2();
    add(0, 0, 1, 0, 0,  3, 1, G, R, 0, 0);
    add(0, 0, 1, 1, 0,  1, 1, G, R, 0, 0);
    add(0, 0, 1, 0, 0,  4, 1, G, R, 0, 0);
    add(0, 0, 1, 0, 0,  3, 1, Y, R, 0, 0);
    add(0, 0, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 0, 1, 0, 0, 16, 1, R, G, 0, 0);
    add(0, 0, 1, 0, 0,  3, 1, R, Y, 0, 0);
    add(0, 0, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 0, 1, 0, 0,  6, 1, G, R, 1, 0);
    add(0, 0, 1, 0, 0,  2, 1, G, R, 0, 0);
    add(0, 0, 1, 0, 0,  3, 1, Y, R, 0, 0);
    // 6: reset in the second B-yellow cycle drops both pending requests.
    rst2();
    add(0, 0, 1, 0, 0,  8, 1, G, R, 0, 0);
    add(0, 0, 1, 0, 0,  3, 1, Y, R, 0, 0);
    add(0, 0, 1, 0, 0,  1, 1, R, R, 0, 0);
    add(0, 0, 1, 1, 0,  1, 1, R, G, 0, 0);
    add(0, 0, 1, 0, 0, 15, 1, R, G, 0, 0);
    add(0, 0, 0, 0, 1,  1, 1, R, Y, 0, 0);
    add(1, 0, 0, 0, 0,  1, 1, R, Y, 0, 0);
    add(0, 0, 0, 0, 0, 12, 1, G, R, 0, 0);

    foreach (rows[i]) begin
      for (int c = 0; c < rows[i].n; c++) begin
        @(negedge clk);
        if (rows[i].chk)
          check($sformatf("row%0d.cyc%0d", i, c), {La, Lb, walk_a, walk_b},
                {rows[i].la, rows[i].lb, rows[i].wa, rows[i].wb});
        reset = rows[i].rst; Ta = rows[i].ta; Tb = rows[i].tb;
        pa_req = rows[i].pa; pb_req = rows[i].pb;
      end
    end

    // Hand-written: reset during all-red, with a B request pending.
    begin
      int  cyc;
      bit  found;
      @(negedge clk); reset = 1; Ta = 0; Tb = 0; pa_req = 0; pb_req = 0;
      @(negedge clk);
      @(negedge clk); reset = 0; pb_req = 1;
      @(negedge clk); pb_req = 0;
      found = 0;
      for (cyc = 0; cyc < 30 && !found; cyc++) begin
        if (La == R && Lb == R) found = 1;
        else @(negedge clk);
      end
      total++;
      if (found) passed++;
      else $display("FAIL allred_wait: got La=%b Lb=%b after 30 cycles, expected all-red", La, Lb);
      reset = 1;
      @(negedge clk); reset = 0;
      check("allred_reset", {La, Lb, walk_a, walk_b}, {G, R, 1'b0, 1'b0});
      // B request must be gone: A green holds past GREEN_MIN with no demand.
      repeat (10) @(negedge clk);
      check("allred_reset_hold", {La, Lb, walk_a, walk_b}, {G, R, 1'b0, 1'b0});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tl_sched_timed.md
Name: tl_sched_timed

Overview:
Timed, demand-driven traffic-light scheduler for a two-street intersection (street A, street B).
- Sequences the A/B light pairs through green, yellow and all-red phases.
- Enforces minimum and maximum green times.
- Arbitrates street A against street B using car sensors (Ta, Tb) and latched pedestrian requests (pa_req, pb_req), each with a timed walk signal.
- Drives the intersection light outputs directly and replaces the untimed, sensor-only controller at the top level.

Parameters:
GREEN_MIN, 8, minimum green cycles per phase
GREEN_MAX, 16, maximum green cycles while the own street still has traffic and the other street has demand
YELLOW_T, 3, yellow cycles
ALLRED_T, 1, all-red clearance cycles
WALK_T, 6, walk-signal cycles (WALK_T <= GREEN_MIN required)
CNT_W, 5, phase timer width (2^CNT_W > GREEN_MAX required)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
Ta  in  1  car present on street A
Tb  in  1  car present on street B
pa_req  in  1  pedestrian request for A-phase walk (level or pulse)
pb_req  in  1  pedestrian request for B-phase walk
La  out  2  street A light: 00 green, 01 yellow, 10 red
Lb  out  2  street B light, same encoding
walk_a  out  1  pedestrian walk during A green
walk_b  out  1  pedestrian walk during B green

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. Sampled only on the rising edge of clk; reset has priority over all other inputs.
- Reset state: S_AG; timer=0; pa_pend=pb_pend=0; walk counters=0. Outputs after the reset edge: La=00, Lb=10, walk_a=0, walk_b=0.
- States and light decode:
  - S_AG: La=00, Lb=10
  - S_AY: La=01, Lb=10
  - S_AR: La=10, Lb=10
  - S_BG: La=10, Lb=00
  - S_BY: La=10, Lb=01
  - S_BR: La=10, Lb=10
- Outputs are decoded from the registered state only (Moore) and change on the edge where the state changes.
- Phase timer:
  - Cleared to 0 on every state change.
  - Otherwise increments each cycle, saturating at 2^CNT_W-1.
- Demand signals: dem_a = Ta | pa_pend; dem_b = Tb | pb_pend.
- Transitions:
  - S_AG -> S_AY when timer >= GREEN_MIN-1 AND walk_a==0 AND dem_b AND (!Ta OR timer >= GREEN_MAX-1).
  - S_AY -> S_AR when timer == YELLOW_T-1.
  - S_AR -> S_BG when timer == ALLRED_T-1.
  - B-side transitions (S_BG -> S_BY -> S_BR -> S_AG) are symmetric, with A and B swapped.
- Phase durations:
  - Green lasts at least GREEN_MIN cycles.
  - Green lasts at most GREEN_MAX cycles while the other street has demand.
  - Green holds indefinitely with no opposing demand.
- Pedestrian pending bits:
  - pa_pend is set on any cycle pa_req==1.
  - On the edge entering S_AG, if (pa_pend | pa_req): walk_a asserts for exactly WALK_T cycles starting in the first S_AG cycle, and pa_pend clears.
  - pa_req asserted during S_AG (other than the entry edge) sets pa_pend; that request is served at the next S_AG entry.
  - B side is symmetric.
- walk_x is never 1 outside its own green state.
- Simultaneous Ta and Tb: the current green holds until GREEN_MAX, then the phase hands over. No starvation.
- Reset asserted in any state, including mid-yellow, mid-all-red or mid-walk: next edge returns to the reset state; all pending bits are lost.

Decomposition:
- Package tl_pkg holds:
  - light encoding constants: LT_GREEN=2'b00, LT_YELLOW=2'b01, LT_RED=2'b10
  - the 3-bit state enumeration for S_AG..S_BR
- Sub-module tl_phase_timer: CNT_W-bit saturating counter with synchronous clear, used for the phase timer.
- The walk counters are small enough to stay inline.

Test Plan:
1. Reset 2 cycles, then Ta=1, Tb=0, no requests for 40 cycles -> La=00, Lb=10, walk_a=walk_b=0 throughout.
2. After reset, Ta=1 and Tb=1 held -> sequence repeats with no starvation:
   - S_AG for 16 cycles
   - La=01 for 3 cycles
   - La=Lb=10 for 1 cycle
   - Lb=00 for 16 cycles
3. After reset, Ta=0, Tb=1 -> S_AG exactly 8 cycles, S_AY 3, S_AR 1, then S_BG held while Ta=0.
4. Ta=Tb=0, 1-cycle pb_req pulse at cycle 2 after reset:
   - S_AG ends at cycle 8, then S_AY, S_AR.
   - walk_b=1 for the first 6 cycles of S_BG.
   - S_BG then holds.
5. pa_req pulse during S_AG cycle 3, with Tb=1, Ta=0 -> walk_a stays 0 in the current S_AG; walk_a=1 for 6 cycles at the next S_AG entry.
6. reset=1 during the second S_BY cycle -> next edge La=00, Lb=10, walk=0, and pending bits cleared (verify no walk on the next S_AG).
